// File: rtl/wb_mem_arbiter_if.sv
// +-----------------------------------------------------------------------+
// | wb_mem_arbiter_if : Wishbone master-side and RAM-side signal bundle   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

interface wb_mem_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32
);
    logic [NUM_MASTERS*AW-1:0]     m_adr_i;
    logic [NUM_MASTERS*DW-1:0]     m_dat_i;
    logic [NUM_MASTERS*DW/8-1:0]   m_sel_i;
    logic [NUM_MASTERS-1:0]        m_we_i;
    logic [NUM_MASTERS-1:0]        m_cyc_i;
    logic [NUM_MASTERS-1:0]        m_stb_i;
    logic [NUM_MASTERS*3-1:0]      m_cti_i;
    logic [NUM_MASTERS*2-1:0]      m_bte_i;
    logic [DW-1:0]                 m_dat_o;
    logic [NUM_MASTERS-1:0]        m_ack_o;
    logic [NUM_MASTERS-1:0]        m_err_o;
    logic [NUM_MASTERS-1:0]        m_rty_o;

    logic [AW-1:0]                 s_adr_o;
    logic [DW-1:0]                 s_dat_o;
    logic [DW/8-1:0]               s_sel_o;
    logic                          s_we_o;
    logic                          s_cyc_o;
    logic                          s_stb_o;
    logic [2:0]                    s_cti_o;
    logic [1:0]                    s_bte_o;
    logic [DW-1:0]                 s_dat_i;
    logic                          s_ack_i;
    logic                          s_err_i;
    logic                          s_rty_i;

    // The arbiter is the slave of the master-side bus; the environment
    // (masters plus RAM) uses the mirrored view.
    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i
    );
endinterface

`default_nettype wire

// File: rtl/wb_mem_arbiter.sv
// +-----------------------------------------------------------------------+
// | wb_mem_arbiter : round-robin Wishbone B3 arbiter with watchdog        |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module wb_mem_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    wb_mem_arbiter_if.slave        bus,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic                   timeout_o
);

    localparam int c_IW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int c_WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_OWNED = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [c_IW-1:0]        last_q, last_d;
    logic [c_WDW-1:0]       wd_cnt_q, wd_cnt_d;
    logic                   timeout_q, timeout_d;

    logic                   w_owned;
    logic                   w_resp;
    logic                   w_wd_fire;
    logic                   w_found;
    int                     w_own;
    int                     w_idx;
    int                     w_pick;

    // While owned, last_q is the owner's index.
    assign w_own     = int'(last_q);
    assign w_owned   = (state_q == c_S_OWNED);
    assign w_resp    = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
    assign w_wd_fire = (TIMEOUT != 0) && w_owned && (wd_cnt_q == c_WDW'(TIMEOUT));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= c_S_IDLE;
            grant_q   <= '0;
            last_q    <= c_IW'(NUM_MASTERS - 1);
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        wd_cnt_d  = '0;
        timeout_d = w_wd_fire;
        w_found   = 1'b0;
        w_pick    = 0;
        w_idx     = 0;
        case (state_q)
            c_S_IDLE: begin
                // Search starts just after the previous owner, wrapping around.
                for (int i = 1; i <= NUM_MASTERS; i++) begin
                    w_idx = int'(last_q) + i;
                    if (w_idx >= NUM_MASTERS) begin
                        w_idx = w_idx - NUM_MASTERS;
                    end
                    if (!w_found && bus.m_cyc_i[w_idx]) begin
                        w_found = 1'b1;
                        w_pick  = w_idx;
                    end
                end
                if (w_found) begin
                    state_d         = c_S_OWNED;
                    grant_d         = '0;
                    grant_d[w_pick] = 1'b1;
                    last_d          = c_IW'(w_pick);
                end
            end
            default: begin
                if (!bus.m_cyc_i[w_own]) begin
                    state_d = c_S_IDLE;
                    grant_d = '0;
                end else if ((TIMEOUT != 0) && bus.m_stb_i[w_own] && !w_resp && !w_wd_fire) begin
                    wd_cnt_d = wd_cnt_q + c_WDW'(1);
                end
            end
        endcase
    end

    always_comb begin
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.s_we_o  = 1'b0;
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_cti_o = '0;
        bus.s_bte_o = '0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        bus.m_rty_o = '0;
        if (w_owned) begin
            bus.s_adr_o          = bus.m_adr_i[w_own*AW +: AW];
            bus.s_dat_o          = bus.m_dat_i[w_own*DW +: DW];
            bus.s_sel_o          = bus.m_sel_i[w_own*(DW/8) +: DW/8];
            bus.s_we_o           = bus.m_we_i[w_own];
            bus.s_cyc_o          = bus.m_cyc_i[w_own];
            bus.s_stb_o          = bus.m_stb_i[w_own] & ~w_wd_fire;
            bus.s_cti_o          = bus.m_cti_i[w_own*3 +: 3];
            bus.s_bte_o          = bus.m_bte_i[w_own*2 +: 2];
            bus.m_ack_o[w_own]   = bus.s_ack_i;
            bus.m_rty_o[w_own]   = bus.s_rty_i;
            bus.m_err_o[w_own]   = bus.s_err_i | w_wd_fire;
        end
    end

    assign bus.m_dat_o = bus.s_dat_i;
    assign grant_o     = grant_q;
    assign timeout_o   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_mem_arbiter.sv
// +-----------------------------------------------------------------------+
// | tb_wb_mem_arbiter : directed self-checking bench for wb_mem_arbiter   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_wb_mem_arbiter;

    localparam int c_N  = 3;
    localparam int c_AW = 32;
    localparam int c_DW = 32;
    localparam int c_TO = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [c_N-1:0] grant;
    logic           tmo;
    int             n_checks = 0;
    int             n_errors = 0;
    int             n_acks;

    wb_mem_arbiter_if #(.NUM_MASTERS(c_N), .AW(c_AW), .DW(c_DW)) bus();

    wb_mem_arbiter #(
        .NUM_MASTERS(c_N),
        .AW         (c_AW),
        .DW         (c_DW),
        .TIMEOUT    (c_TO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .bus      (bus),
        .grant_o  (grant),
        .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
        bus.m_cyc_i[k]             = cyc;
        bus.m_stb_i[k]             = stb;
        bus.m_we_i[k]              = we;
        bus.m_adr_i[k*c_AW +: c_AW] = adr;
        bus.m_dat_i[k*c_DW +: c_DW] = dat;
        bus.m_sel_i[k*4 +: 4]      = 4'hF;
        bus.m_cti_i[k*3 +: 3]      = cti;
        bus.m_bte_i[k*2 +: 2]      = 2'b00;
    endtask

    task automatic clear_inputs();
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.m_we_i  = '0;
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.m_cti_i = '0;
        bus.m_bte_i = '0;
        bus.s_ack_i = 1'b0;
        bus.s_err_i = 1'b0;
        bus.s_rty_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Current owner k gets one acked beat, then drops cyc; checks the dead cycle.
    task automatic xfer_one(input int k);
        bus.s_ack_i = 1'b1;
        settle();
        check($sformatf("ack_m%0d", k), bus.m_ack_o, 64'(1 << k));
        step();
        drive(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        bus.s_ack_i = 1'b0;
        step();
        check($sformatf("dead_cycle_after_m%0d", k), grant, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        bus.s_dat_i = 32'h1234_5678;
        #12;
        check("rst_grant",  grant, 0);
        check("rst_s_cyc",  bus.s_cyc_o, 0);
        check("rst_s_stb",  bus.s_stb_o, 0);
        check("rst_m_ack",  bus.m_ack_o, 0);
        check("rst_tmo",    tmo, 0);
        check("rst_m_dat",  bus.m_dat_o, 32'h1234_5678);
        step();
        rst_n = 1'b1;

        // Master 1 single write
        drive(1, 1'b1, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'b000);
        settle();
        check("t1_pre_grant", grant, 0);
        step();
        check("t1_grant", grant, 3'b010);
        check("t1_s_cyc", bus.s_cyc_o, 1);
        check("t1_s_adr", bus.s_adr_o, 32'h100);
        check("t1_s_dat", bus.s_dat_o, 32'hDEAD_BEEF);
        check("t1_s_we",  bus.s_we_o, 1);
        check("t1_s_sel", bus.s_sel_o, 4'hF);
        xfer_one(1);

        // Three simultaneous requesters from reset
        do_reset();
        for (int k = 0; k < c_N; k++) drive(k, 1'b1, 1'b1, 1'b0, 32'(k * 16), 32'h0, 3'b000);
        step();
        check("t2_grant0", grant, 3'b001);
        xfer_one(0);
        step();
        check("t2_grant1", grant, 3'b010);
        xfer_one(1);
        step();
        check("t2_grant2", grant, 3'b100);
        check("t2_s_adr2", bus.s_adr_o, 32'h20);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 3'b000);
        xfer_one(2);
        step();
        check("t2_grant0_again", grant, 3'b001);
        xfer_one(0);

        // Master 0 incrementing burst with master 2 waiting
        do_reset();
        drive(0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 3'b010);
        drive(2, 1'b1, 1'b1, 1'b0, 32'h900, 32'h0, 3'b000);
        step();
        check("t3_grant", grant, 3'b001);
        n_acks = 0;
        for (int b = 0; b < 8; b++) begin
            drive(0, 1'b1, 1'b1, 1'b0, 32'(32'h200 + 4 * b), 32'h0, (b == 7) ? 3'b111 : 3'b010);
            bus.s_ack_i = 1'b1;
            settle();
            check("t3_burst_grant", grant, 3'b001);
            check("t3_burst_adr", bus.s_adr_o, 64'(32'h200 + 4 * b));
            if (bus.m_ack_o == 3'b001) n_acks++;
            step();
        end
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        bus.s_ack_i = 1'b0;
        settle();
        check("t3_cyc_drop_immediate", bus.s_cyc_o, 0);
        check("t3_ack_count", 64'(n_acks), 8);
        step();
        check("t3_dead_cycle", grant, 0);
        step();
        check("t3_grant2", grant, 3'b100);
        xfer_one(2);

        // Watchdog: slave never answers
        drive(0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 3'b000);
        step();
        check("t4_grant", grant, 3'b001);
        for (int c = 0; c < c_TO; c++) begin
            check("t4_stb_live", bus.s_stb_o, 1);
            check("t4_no_err",   bus.m_err_o, 0);
            check("t4_no_tmo",   tmo, 0);
            step();
        end
        check("t4_err_fire",   bus.m_err_o, 3'b001);
        check("t4_stb_masked", bus.s_stb_o, 0);
        check("t4_tmo_not_yet", tmo, 0);
        step();
        check("t4_tmo_pulse",  tmo, 1);
        check("t4_err_clear",  bus.m_err_o, 0);
        check("t4_grant_held", grant, 3'b001);
        check("t4_stb_again",  bus.s_stb_o, 1);
        step();
        check("t4_tmo_single", tmo, 0);
        check("t4_grant_held2", grant, 3'b001);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        step();
        check("t4_release", grant, 0);

        // Reset asserted mid-transfer
        drive(1, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 3'b010);
        step();
        check("t5_grant", grant, 3'b010);
        bus.s_ack_i = 1'b1;
        settle();
        check("t5_ack", bus.m_ack_o, 3'b010);
        rst_n = 1'b0;
        settle();
        check("t5_rst_grant", grant, 0);
        check("t5_rst_s_cyc", bus.s_cyc_o, 0);
        check("t5_rst_m_ack", bus.m_ack_o, 0);
        step();
        drive(0, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 3'b000);
        bus.s_ack_i = 1'b0;
        rst_n = 1'b1;
        step();
        check("t5_first_after_rst", grant, 3'b001);

        // Owner drops cyc in the same cycle as the slave ack
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        bus.s_ack_i = 1'b1;
        settle();
        check("t6_ack_fwd",  bus.m_ack_o, 3'b001);
        check("t6_s_cyc",    bus.s_cyc_o, 0);
        step();
        bus.s_ack_i = 1'b0;
        check("t6_release",  grant, 0);
        step();
        check("t6_next_m1",  grant, 3'b010);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
